sd_spi_card: RTL and testbench

- SPI-mode SD card responder: the card side of the protocol that the host-side SD interface drives.
- Provides a synthesizable card model with internal sector storage.
- Used in the simulation bench to exercise the host read/write path, and as an on-FPGA loopback target.
- Sits directly on the sd_cs_n/sd_clk/sd_mosi/sd_miso wires. Oversamples the SPI clock with the system clock.

---
 rtl/sd_spi_if.sv | 10 +
 rtl/sd_spi_card.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_sd_spi_card.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_if.sv
// SPI-mode SD bus wires shared between a host and a card.
interface sd_spi_if;
  logic sd_cs_n;
  logic sd_clk;
  logic sd_mosi;
  logic sd_miso;

  modport master (output sd_cs_n, output sd_clk, output sd_mosi, input sd_miso);
  modport slave  (input sd_cs_n, input sd_clk, input sd_mosi, output sd_miso);
endinterface

// File: rtl/sd_spi_card.sv
// SPI-mode SD card responder with internal sector storage.
// The SPI pins are oversampled by clk; one byte is exchanged per 8 sd_clk periods.
// The state names the byte currently being shifted out (or, for WR_*, shifted in).
//
// state    | meaning
// HUNT     | idle, sends 0xFF, looks for a 01xxxxxx command start byte
// ARG      | collecting 4 argument bytes and the (ignored) CRC byte
// RESP     | sending the NCR 0xFF and then the response bytes
// RD_GAP   | sending 0xFF access-latency bytes
// RD_TOKEN | sending the 0xFE start token
// RD_DATA  | sending the 512 sector bytes
// RD_CRC   | sending two 0xFF CRC bytes
// WR_TOKEN | waiting for the host 0xFE start token
// WR_DATA  | receiving 512 bytes into the staging buffer
// WR_CRC   | receiving two CRC bytes, commit after the second
// WR_RESP  | sending the 0x05 data response
// WR_BUSY  | sending 0x00 busy bytes
module sd_spi_card #(
  parameter int Sectors     = 4,
  parameter int InitPolls   = 2,
  parameter int ReadLatency = 2,
  parameter int BusyBytes   = 4
) (
  input  logic       clk,
  input  logic       rst,
  sd_spi_if.slave    sd,
  output logic       card_ready,
  output logic       cmd_strobe,
  output logic [5:0] cmd_index,
  output logic [3:0] state_dbg
);
  localparam int SW = (Sectors > 1) ? $clog2(Sectors) : 1;
  localparam int Depth = Sectors * 512;

  typedef enum logic [3:0] {
    HUNT = 4'd0, ARG = 4'd1, RESP = 4'd2, RD_GAP = 4'd3, RD_TOKEN = 4'd4, RD_DATA = 4'd5,
    RD_CRC = 4'd6, WR_TOKEN = 4'd7, WR_DATA = 4'd8, WR_CRC = 4'd9, WR_RESP = 4'd10,
    WR_BUSY = 4'd11
  } state_e;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2} op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [1:0]    cs_sync_q, cs_sync_d;
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    mosi_sync_q, mosi_sync_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic          miso_q, miso_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [8:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic [5:0]    frame_q, frame_d;
  logic [39:0]   resp_q, resp_d;
  logic [2:0]    resp_cnt_q, resp_cnt_d;
  logic [SW-1:0] sector_q, sector_d;
  logic          ready_q, ready_d;
  logic [7:0]    poll_q, poll_d;
  logic          app_q, app_d;
  logic          strobe_q, strobe_d;
  logic [5:0]    index_q, index_d;

  // Flat byte arrays so a whole sector can be committed in one cycle.
  logic [Depth*8-1:0] mem_q;
  logic [4095:0]      stage_q;
  logic               stage_we, commit;

  logic       cs_high, sclk_rise, sclk_fall, byte_done;
  logic [7:0] rx_byte, rd_byte, idle_r1;

  assign cs_high   = cs_sync_q[1];
  assign sclk_rise = clk_sync_q[1] & ~clk_sync_q[2];
  assign sclk_fall = ~clk_sync_q[1] & clk_sync_q[2];
  assign rx_byte   = {rx_q, mosi_sync_q[1]};
  assign byte_done = sclk_rise & ~cs_high & (bit_cnt_q == 3'd7);
  assign rd_byte   = mem_q[{sector_q, idx_q, 3'b000} +: 8];
  assign idle_r1   = {7'd0, ~ready_q};

  assign sd.sd_miso = miso_q;
  assign card_ready = ready_q;
  assign cmd_strobe = strobe_q;
  assign cmd_index  = index_q;
  assign state_dbg  = state_q;

  // Synchronizers, bit shifting, and the byte-level protocol FSM.
  always_comb begin
    cs_sync_d   = {cs_sync_q[0], sd.sd_cs_n};
    clk_sync_d  = {clk_sync_q[1:0], sd.sd_clk};
    mosi_sync_d = {mosi_sync_q[0], sd.sd_mosi};
    state_d     = state_q;
    op_d        = op_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    frame_d     = frame_q;
    resp_d      = resp_q;
    resp_cnt_d  = resp_cnt_q;
    sector_d    = sector_q;
    ready_d     = ready_q;
    poll_d      = poll_q;
    app_d       = app_q;
    strobe_d    = 1'b0;
    index_d     = index_q;
    stage_we    = 1'b0;
    commit      = 1'b0;

    if (cs_high) begin
      state_d   = HUNT;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b1;
      tx_d      = 8'hFF;
    end else begin
      if (sclk_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b1};
      end
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        tx_d = 8'hFF;
        case (state_q)
          HUNT: begin
            if (rx_byte[7:6] == 2'b01) begin
              state_d = ARG;
              frame_d = rx_byte[5:0];
              cnt_d   = 8'd4;
            end
          end
          ARG: begin
            if (cnt_q != 8'd0) begin
              arg_d = {arg_q[23:0], rx_byte};
              cnt_d = cnt_q - 8'd1;
            end else begin
              state_d    = RESP;
              strobe_d   = 1'b1;
              index_d    = frame_q;
              app_d      = 1'b0;
              op_d       = OP_NONE;
              idx_d      = 9'd0;
              sector_d   = arg_q[SW-1:0];
              resp_cnt_d = 3'd1;
              resp_d     = {idle_r1 | 8'h04, 32'd0};
              case (frame_q)
                6'd0: begin
                  resp_d  = {8'h01, 32'd0};
                  ready_d = 1'b0;
                  poll_d  = 8'd0;
                end
                6'd8: begin
                  resp_d     = {idle_r1, 8'h00, 8'h00, 8'h01, arg_q[7:0]};
                  resp_cnt_d = 3'd5;
                end
                6'd55: begin
                  resp_d = {idle_r1, 32'd0};
                  app_d  = 1'b1;
                end
                6'd41: begin
                  if (app_q) begin
                    if (poll_q < 8'(InitPolls)) begin
                      resp_d = {8'h01, 32'd0};
                      poll_d = poll_q + 8'd1;
                    end else begin
                      resp_d  = {8'h00, 32'd0};
                      ready_d = 1'b1;
                    end
                  end
                end
                6'd58: begin
                  resp_d     = {idle_r1, 32'hC0FF_8000};
                  resp_cnt_d = 3'd5;
                end
                6'd17, 6'd24: begin
                  if (!ready_q) begin
                    resp_d = {8'h05, 32'd0};
                  end else if (arg_q >= 32'(Sectors)) begin
                    resp_d = {8'h40, 32'd0};
                  end else begin
                    resp_d = {8'h00, 32'd0};
                    op_d   = (frame_q == 6'd17) ? OP_READ : OP_WRITE;
                  end
                end
                default: ;
              endcase
            end
          end
          RESP: begin
            if (resp_cnt_q != 3'd0) begin
              tx_d       = resp_q[39:32];
              resp_d     = {resp_q[31:0], 8'h00};
              resp_cnt_d = resp_cnt_q - 3'd1;
            end else begin
              case (op_q)
                OP_READ: begin
                  if (ReadLatency > 0) begin
                    state_d = RD_GAP;
                    cnt_d   = 8'(ReadLatency - 1);
                  end else begin
                    state_d = RD_TOKEN;
                    tx_d    = 8'hFE;
                  end
                end
                OP_WRITE: state_d = WR_TOKEN;
                default:  state_d = HUNT;
              endcase
            end
          end
          RD_GAP: begin
            if (cnt_q == 8'd0) begin
              state_d = RD_TOKEN;
              tx_d    = 8'hFE;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          RD_TOKEN: begin
            state_d = RD_DATA;
            tx_d    = rd_byte;
            idx_d   = idx_q + 9'd1;
          end
          RD_DATA: begin
            // idx wraps to 0 once byte 511 has been loaded
            if (idx_q == 9'd0) begin
              state_d = RD_CRC;
              cnt_d   = 8'd1;
            end else begin
              tx_d  = rd_byte;
              idx_d = idx_q + 9'd1;
            end
          end
          RD_CRC: begin
            if (cnt_q == 8'd0) state_d = HUNT;
            else cnt_d = cnt_q - 8'd1;
          end
          WR_TOKEN: begin
            if (rx_byte == 8'hFE) begin
              state_d = WR_DATA;
              idx_d   = 9'd0;
            end
          end
          WR_DATA: begin
            stage_we = 1'b1;
            idx_d    = idx_q + 9'd1;
            if (idx_q == 9'd511) begin
              state_d = WR_CRC;
              cnt_d   = 8'd1;
            end
          end
          WR_CRC: begin
            if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
            end else begin
              commit  = 1'b1;
              state_d = WR_RESP;
              tx_d    = 8'h05;
            end
          end
          WR_RESP: begin
            if (BusyBytes > 0) begin
              state_d = WR_BUSY;
              tx_d    = 8'h00;
              cnt_d   = 8'(BusyBytes - 1);
            end else begin
              state_d = HUNT;
            end
          end
          WR_BUSY: begin
            if (cnt_q == 8'd0) begin
              state_d = HUNT;
            end else begin
              cnt_d = cnt_q - 8'd1;
              tx_d  = 8'h00;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  // Control and protocol registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      op_q        <= OP_NONE;
      cs_sync_q   <= 2'b11;
      clk_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b11;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'hFF;
      miso_q      <= 1'b1;
      cnt_q       <= 8'd0;
      idx_q       <= 9'd0;
      arg_q       <= 32'd0;
      frame_q     <= 6'd0;
      resp_q      <= 40'd0;
      resp_cnt_q  <= 3'd0;
      sector_q    <= '0;
      ready_q     <= 1'b0;
      poll_q      <= 8'd0;
      app_q       <= 1'b0;
      strobe_q    <= 1'b0;
      index_q     <= 6'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cs_sync_q   <= cs_sync_d;
      clk_sync_q  <= clk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      frame_q     <= frame_d;
      resp_q      <= resp_d;
      resp_cnt_q  <= resp_cnt_d;
      sector_q    <= sector_d;
      ready_q     <= ready_d;
      poll_q      <= poll_d;
      app_q       <= app_d;
      strobe_q    <= strobe_d;
      index_q     <= index_d;
    end
  end

  // Sector storage and write staging; neither is touched by reset.
  always_ff @(posedge clk) begin
    if (stage_we) stage_q[{idx_q, 3'b000} +: 8] <= rx_byte;
    if (commit) mem_q[{sector_q, 12'd0} +: 4096] <= stage_q;
  end
endmodule

// File: tb/tb_sd_spi_card.sv
// Byte-level host model driving the SD card responder over SPI mode 0.
module tb_sd_spi_card;
  localparam int HalfSck = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       card_ready, cmd_strobe;
  logic [5:0] cmd_index;
  logic [3:0] state_dbg;

  sd_spi_if bus ();

  sd_spi_card #(.Sectors(4), .InitPolls(2), .ReadLatency(2), .BusyBytes(4)) dut (
    .clk(clk), .rst(rst), .sd(bus), .card_ready(card_ready),
    .cmd_strobe(cmd_strobe), .cmd_index(cmd_index), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] miso;
    bit         chk;
    string      name;
  } vec_t;
  typedef struct {
    logic [7:0] miso;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   strobes = 0;
  int   ncmds = 0;

  always @(negedge clk) if (cmd_strobe === 1'b1) strobes++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.sd_mosi = tx[i];
      #HalfSck bus.sd_clk = 1'b1;
      rx[i] = bus.sd_miso;
      #HalfSck bus.sd_clk = 1'b0;
    end
  endtask

  function automatic void add(input logic [7:0] m, input logic [7:0] e, input bit c,
                              input string n);
    vec_t v;
    v.mosi = m;
    v.miso = e;
    v.chk  = c;
    v.name = n;
    vecs.push_back(v);
  endfunction

  // Six command bytes; the card answers 0xFF throughout, then NCR 0xFF.
  function automatic void add_cmd(input logic [5:0] idx, input logic [31:0] arg);
    add({2'b01, idx}, 8'hFF, 1'b1, "cmd_ff");
    for (int i = 3; i >= 0; i--) add(arg[8*i +: 8], 8'hFF, 1'b1, "cmd_ff");
    add((idx == 6'd0) ? 8'h95 : 8'h87, 8'hFF, 1'b1, "cmd_ff");
    add(8'hFF, 8'hFF, 1'b1, "ncr");
    ncmds++;
  endfunction

  task automatic run_vecs();
    logic [7:0] rx;
    exp_t       e;
    foreach (vecs[k]) begin
      if (vecs[k].chk) sb.push_back('{vecs[k].miso, vecs[k].name});
      spi_byte(vecs[k].mosi, rx);
      if (vecs[k].chk) begin
        e = sb.pop_front();
        check(e.name, 32'(rx), 32'(e.miso));
      end
    end
    vecs.delete();
  endtask

  initial begin
    rst         = 1'b1;
    bus.sd_cs_n = 1'b1;
    bus.sd_clk  = 1'b0;
    bus.sd_mosi = 1'b1;
    #33 rst = 1'b0;
    #20;
    check("rst_miso", 32'(bus.sd_miso), 32'd1);
    check("rst_ready", 32'(card_ready), 32'd0);
    check("rst_strobe", 32'(cmd_strobe), 32'd0);
    check("rst_index", 32'(cmd_index), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    bus.sd_cs_n = 1'b0;
    #60;

    // CMD0, with a couple of non-start bytes in Hunt first
    add(8'h80, 8'hFF, 1'b1, "hunt_ign");
    add(8'h3F, 8'hFF, 1'b1, "hunt_ign");
    add_cmd(6'd0, 32'd0);
    add(8'hFF, 8'h01, 1'b1, "cmd0_r1");
    run_vecs();
    check("cmd0_strobes", 32'(strobes), 32'd1);
    check("cmd0_index", 32'(cmd_index), 32'd0);
    check("cmd0_ready", 32'(card_ready), 32'd0);

    // CMD8 echo, CMD17 before init, CMD58 OCR
    add_cmd(6'd8, 32'h0000_01AA);
    add(8'hFF, 8'h01, 1'b1, "r7_r1");
    add(8'hFF, 8'h00, 1'b1, "r7_b1");
    add(8'hFF, 8'h00, 1'b1, "r7_b2");
    add(8'hFF, 8'h01, 1'b1, "r7_b3");
    add(8'hFF, 8'hAA, 1'b1, "r7_echo");
    add_cmd(6'd17, 32'd1);
    add(8'hFF, 8'h05, 1'b1, "rd_noinit_r1");
    for (int i = 0; i < 3; i++) add(8'hFF, 8'hFF, 1'b1, "rd_noinit_nodata");
    add_cmd(6'd58, 32'd0);
    add(8'hFF, 8'h01, 1'b1, "r3_r1");
    add(8'hFF, 8'hC0, 1'b1, "ocr0");
    add(8'hFF, 8'hFF, 1'b1, "ocr1");
    add(8'hFF, 8'h80, 1'b1, "ocr2");
    add(8'hFF, 8'h00, 1'b1, "ocr3");
    run_vecs();
    check("cmd58_index", 32'(cmd_index), 32'd58);

    // Initialization polling
    for (int r = 0; r < 3; r++) begin
      add_cmd(6'd55, 32'd0);
      add(8'hFF, 8'h01, 1'b1, "cmd55_r1");
      add_cmd(6'd41, 32'h4000_0000);
      add(8'hFF, (r < 2) ? 8'h01 : 8'h00, 1'b1, "acmd41_r1");
      run_vecs();
      check("acmd41_ready", 32'(card_ready), (r < 2) ? 32'd0 : 32'd1);
    end
    add_cmd(6'd41, 32'd0);
    add(8'hFF, 8'h04, 1'b1, "bare41_r1");
    add_cmd(6'd17, 32'd4);
    add(8'hFF, 8'h40, 1'b1, "rd_range_r1");
    for (int i = 0; i < 4; i++) add(8'hFF, 8'hFF, 1'b1, "rd_range_nodata");
    run_vecs();

    // Full write of sector 1
    add_cmd(6'd24, 32'd1);
    add(8'hFF, 8'h00, 1'b1, "wr_r1");
    add(8'hFF, 8'hFF, 1'b1, "wr_wait");
    add(8'hFE, 8'hFF, 1'b1, "wr_token");
    for (int i = 0; i < 512; i++) add(8'(i), 8'hFF, 1'b1, "wr_data");
    add(8'hFF, 8'hFF, 1'b1, "wr_crc");
    add(8'hFF, 8'hFF, 1'b1, "wr_crc");
    add(8'hFF, 8'h05, 1'b1, "wr_dresp");
    for (int i = 0; i < 4; i++) add(8'hFF, 8'h00, 1'b1, "wr_busy");
    add(8'hFF, 8'hFF, 1'b1, "wr_busy_end");
    run_vecs();

    // Read it back
    add_cmd(6'd17, 32'd1);
    add(8'hFF, 8'h00, 1'b1, "rd_r1");
    add(8'hFF, 8'hFF, 1'b1, "rd_gap");
    add(8'hFF, 8'hFF, 1'b1, "rd_gap");
    add(8'hFF, 8'hFE, 1'b1, "rd_token");
    for (int i = 0; i < 512; i++) add(8'hFF, 8'(i), 1'b1, "rd_data");
    add(8'hFF, 8'hFF, 1'b1, "rd_crc");
    add(8'hFF, 8'hFF, 1'b1, "rd_crc");
    add(8'hFF, 8'hFF, 1'b1, "rd_hunt");
    run_vecs();

    // Write aborted by deselect after 100 data bytes
    add_cmd(6'd24, 32'd1);
    add(8'hFF, 8'h00, 1'b1, "abort_r1");
    add(8'hFE, 8'hFF, 1'b1, "abort_token");
    for (int i = 0; i < 100; i++) add(8'(~i), 8'hFF, 1'b1, "abort_data");
    run_vecs();
    check("abort_state_wrdata", 32'(state_dbg), 32'd8);
    bus.sd_cs_n = 1'b1;
    #200;
    check("desel_miso", 32'(bus.sd_miso), 32'd1);
    check("desel_state", 32'(state_dbg), 32'd0);
    bus.sd_cs_n = 1'b0;
    #60;

    add_cmd(6'd17, 32'd1);
    add(8'hFF, 8'h00, 1'b1, "rd2_r1");
    add(8'hFF, 8'hFF, 1'b1, "rd2_gap");
    add(8'hFF, 8'hFF, 1'b1, "rd2_gap");
    add(8'hFF, 8'hFE, 1'b1, "rd2_token");
    for (int i = 0; i < 120; i++) add(8'hFF, 8'(i), 1'b1, "rd2_data");
    run_vecs();
    bus.sd_cs_n = 1'b1;
    #200;
    check("desel_rd_miso", 32'(bus.sd_miso), 32'd1);
    check("strobe_count", 32'(strobes), 32'(ncmds));
    check("final_index", 32'(cmd_index), 32'd17);
    check("final_ready", 32'(card_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
